// File: rtl/add8_eval_pkg.sv
// ---------------------------------------------------------------------------
// add8_eval_pkg
//
// Purpose : Shared definitions for the approximate-adder error monitor:
//           FSM state encoding, pipeline depth and helper functions that
//           derive datapath / accumulator widths from W (operand width) and
//           NLOG (log2 of the maximum run length).
//
// Contents:
//   mon_state_t  - monitor FSM states (IDLE, RUN, DRAIN, DONE)
//   PIPE_DEPTH   - cycles from an accepted vector to its effect on the
//                  statistic outputs
//   sum_w        - exact sum width              (W+1)
//   diff_w       - signed difference width      (W+2)
//   sq_w         - squared error width          (2(W+1))
//   pc_w         - per-vector popcount width    (enough for 0..W+1)
//   cnt_w        - run-length / error counter   (NLOG+1)
//   abs_acc_w    - |error| accumulator          (W+1+NLOG)
//   sq_acc_w     - error^2 accumulator          (2(W+1)+NLOG)
//   hd_acc_w     - Hamming-distance accumulator (NLOG+5, sized for W=8)
// ---------------------------------------------------------------------------
package add8_eval_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mon_state_t;

   localparam int PIPE_DEPTH = 3;

   function automatic int sum_w(input int w);
      return w + 1;
   endfunction

   function automatic int diff_w(input int w);
      return w + 2;
   endfunction

   function automatic int sq_w(input int w);
      return 2 * (w + 1);
   endfunction

   // A (w+1)-bit xor can have up to w+1 ones, so w+2 distinct values.
   function automatic int pc_w(input int w);
      return $clog2(w + 2);
   endfunction

   function automatic int cnt_w(input int nlog);
      return nlog + 1;
   endfunction

   function automatic int abs_acc_w(input int w, input int nlog);
      return w + 1 + nlog;
   endfunction

   function automatic int sq_acc_w(input int w, input int nlog);
      return 2 * (w + 1) + nlog;
   endfunction

   function automatic int hd_acc_w(input int nlog);
      return nlog + 5;
   endfunction

endpackage

// File: rtl/add8_err_calc.sv
// ---------------------------------------------------------------------------
// add8_err_calc
//
// Purpose : First two pipeline stages of the error monitor.
//           S1 registers the exact sum S = A + B and the signed difference
//           D = O - S. S2 registers |D|, D^2, popcount(O xor S) and a
//           nonzero-error flag. A valid bit travels alongside the data.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears valid bits)
//   in_valid   in   a vector is transferred this cycle
//   a, b       in   W-bit operands
//   o          in   W+1-bit approximate result
//   s1_valid   out  stage-1 holds a vector (used by the drain logic)
//   out_valid  out  stage-2 holds a vector; outputs below are meaningful
//   err_flag   out  O != A+B
//   abs_err    out  |O - (A+B)|
//   sq_err     out  (O - (A+B))^2
//   hd         out  popcount(O xor (A+B))
// ---------------------------------------------------------------------------
module add8_err_calc
   import add8_eval_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [W-1:0]          a,
   input  logic [W-1:0]          b,
   input  logic [W:0]            o,
   output logic                  s1_valid,
   output logic                  out_valid,
   output logic                  err_flag,
   output logic [W:0]            abs_err,
   output logic [2*W+1:0]        sq_err,
   output logic [pc_w(W)-1:0]    hd
);

   localparam int SUM_W  = sum_w(W);
   localparam int DIFF_W = diff_w(W);
   localparam int SQ_W   = sq_w(W);
   localparam int PC_W   = pc_w(W);

   // ------------------------------------------------------------------
   // Stage 1: exact sum and signed difference
   // ------------------------------------------------------------------
   logic [SUM_W-1:0]         sum_c;
   logic signed [DIFF_W-1:0] diff_c;

   assign sum_c  = {1'b0, a} + {1'b0, b};
   assign diff_c = $signed({1'b0, o}) - $signed({1'b0, sum_c});

   logic                     s1_valid_reg;
   logic [SUM_W-1:0]         s1_sum_reg;
   logic [SUM_W-1:0]         s1_o_reg;
   logic signed [DIFF_W-1:0] s1_diff_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_sum_reg   <= '0;
         s1_o_reg     <= '0;
         s1_diff_reg  <= '0;
      end else begin
         s1_valid_reg <= in_valid;
         // Data registers only load on a real transfer so that garbage on
         // the input bus during stalls never reaches the datapath.
         if (in_valid) begin
            s1_sum_reg  <= sum_c;
            s1_o_reg    <= o;
            s1_diff_reg <= diff_c;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: magnitude, square, Hamming distance, error flag
   // ------------------------------------------------------------------
   // |D| never exceeds 2^(W+1)-1, so two's-complement negation of the low
   // SUM_W bits is exact; the sign bit only selects the branch.
   logic [SUM_W-1:0] abs_c;
   logic [SQ_W-1:0]  sq_c;
   logic [SUM_W-1:0] xor_c;
   logic             nz_c;

   assign abs_c = s1_diff_reg[DIFF_W-1] ? (~s1_diff_reg[SUM_W-1:0] + 1'b1)
                                        : s1_diff_reg[SUM_W-1:0];
   assign sq_c  = {{SUM_W{1'b0}}, abs_c} * {{SUM_W{1'b0}}, abs_c};
   assign xor_c = s1_o_reg ^ s1_sum_reg;
   assign nz_c  = |s1_diff_reg;

   // Popcount as a running-sum chain over the xor bits.
   logic [PC_W-1:0] pc_chain [0:SUM_W];
   assign pc_chain[0] = '0;

   generate
      for (genvar gi = 0; gi < SUM_W; gi++) begin : g_popcount
         assign pc_chain[gi+1] = pc_chain[gi] + PC_W'(xor_c[gi]);
      end
   endgenerate

   logic             s2_valid_reg;
   logic [SUM_W-1:0] s2_abs_reg;
   logic [SQ_W-1:0]  s2_sq_reg;
   logic [PC_W-1:0]  s2_pc_reg;
   logic             s2_nz_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         s2_abs_reg   <= '0;
         s2_sq_reg    <= '0;
         s2_pc_reg    <= '0;
         s2_nz_reg    <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_abs_reg <= abs_c;
            s2_sq_reg  <= sq_c;
            s2_pc_reg  <= pc_chain[SUM_W];
            s2_nz_reg  <= nz_c;
         end
      end
   end

   assign s1_valid  = s1_valid_reg;
   assign out_valid = s2_valid_reg;
   assign err_flag  = s2_nz_reg;
   assign abs_err   = s2_abs_reg;
   assign sq_err    = s2_sq_reg;
   assign hd        = s2_pc_reg;

endmodule

// File: rtl/add8_err_monitor.sv
// ---------------------------------------------------------------------------
// add8_err_monitor
//
// Purpose : Collects error statistics for an approximate W-bit adder.
//           For each transferred vector (A, B, O) the exact sum A+B is
//           compared with O and the run accumulates: number of erroneous
//           vectors, sum of |error|, sum of error^2, worst-case |error|
//           and total Hamming distance. A run of num_vectors vectors is
//           started with start; done pulses once all results are in.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset, aborts any run
//   start        in   begin a run (honoured in IDLE or DONE only)
//   num_vectors  in   run length, sampled on an accepted start (0..2^NLOG)
//   in_valid     in   vector present on A/B/O
//   in_ready     out  vector accepted this cycle if in_valid
//   A, B         in   operands
//   O            in   approximate sum
//   busy         out  run in progress (RUN or DRAIN)
//   done         out  one-cycle pulse on entering DONE
//   err_count    out  vectors with O != A+B
//   sum_abs_err  out  sum of |O-(A+B)|
//   sum_sq_err   out  sum of (O-(A+B))^2
//   wce          out  largest |O-(A+B)| in the run
//   hd_total     out  sum of popcount(O xor (A+B))
// ---------------------------------------------------------------------------
module add8_err_monitor
   import add8_eval_pkg::*;
#(
   parameter int W    = 8,
   parameter int NLOG = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [NLOG:0]             num_vectors,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              A,
   input  logic [W-1:0]              B,
   input  logic [W:0]                O,
   output logic                      busy,
   output logic                      done,
   output logic [NLOG:0]             err_count,
   output logic [W+NLOG:0]           sum_abs_err,
   output logic [2*(W+1)+NLOG-1:0]   sum_sq_err,
   output logic [W:0]                wce,
   output logic [NLOG+4:0]           hd_total
);

   localparam int CNT_W     = cnt_w(NLOG);
   localparam int SUM_W     = sum_w(W);
   localparam int SQ_W      = sq_w(W);
   localparam int PC_W      = pc_w(W);
   localparam int ABS_ACC_W = abs_acc_w(W, NLOG);
   localparam int SQ_ACC_W  = sq_acc_w(W, NLOG);
   localparam int HD_ACC_W  = hd_acc_w(NLOG);

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   mon_state_t       state_reg, state_next;
   logic [CNT_W-1:0] remaining_reg, remaining_next;
   logic             done_reg, done_next;
   logic             clear_stats;
   logic             transfer;

   // Pipeline status from the calc stages
   logic             s1_valid;
   logic             s2_valid;
   logic             s2_err;
   logic [SUM_W-1:0] s2_abs;
   logic [SQ_W-1:0]  s2_sq;
   logic [PC_W-1:0]  s2_pc;

   assign in_ready = (state_reg == ST_RUN) && (remaining_reg != '0);
   assign transfer = in_valid && in_ready;
   assign busy     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign done     = done_reg;

   // ------------------------------------------------------------------
   // Datapath stages S1-S2
   // ------------------------------------------------------------------
   add8_err_calc #(
      .W (W)
   ) u_calc (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (transfer),
      .a         (A),
      .b         (B),
      .o         (O),
      .s1_valid  (s1_valid),
      .out_valid (s2_valid),
      .err_flag  (s2_err),
      .abs_err   (s2_abs),
      .sq_err    (s2_sq),
      .hd        (s2_pc)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         remaining_reg <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      done_next      = 1'b0;
      clear_stats    = 1'b0;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               clear_stats    = 1'b1;
               remaining_next = num_vectors;
               state_next     = (num_vectors == '0) ? ST_DRAIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (transfer) begin
               remaining_next = remaining_reg - CNT_W'(1);
               if (remaining_reg == CNT_W'(1)) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // S3 absorbs whatever sits in S2 on this same edge, so once S1
            // is empty the last result lands exactly as DONE is entered.
            if (!s1_valid) begin
               state_next = ST_DONE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Stage S3: accumulators. Widths cover 2^NLOG worst-case vectors, so
   // plain wrap-free addition suffices.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0]     err_count_reg;
   logic [ABS_ACC_W-1:0] sum_abs_reg;
   logic [SQ_ACC_W-1:0]  sum_sq_reg;
   logic [SUM_W-1:0]     wce_reg;
   logic [HD_ACC_W-1:0]  hd_total_reg;

   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         err_count_reg <= '0;
         sum_abs_reg   <= '0;
         sum_sq_reg    <= '0;
         wce_reg       <= '0;
         hd_total_reg  <= '0;
      end else if (s2_valid) begin
         err_count_reg <= err_count_reg + CNT_W'(s2_err);
         sum_abs_reg   <= sum_abs_reg + ABS_ACC_W'(s2_abs);
         sum_sq_reg    <= sum_sq_reg + SQ_ACC_W'(s2_sq);
         hd_total_reg  <= hd_total_reg + HD_ACC_W'(s2_pc);
         if (s2_abs > wce_reg) begin
            wce_reg <= s2_abs;
         end
      end
   end

   assign err_count   = err_count_reg;
   assign sum_abs_err = sum_abs_reg;
   assign sum_sq_err  = sum_sq_reg;
   assign wce         = wce_reg;
   assign hd_total    = hd_total_reg;

endmodule
